// File: rtl/dpwm_duty_capture.sv
// Receive end of the DPWM path: measures high time and period of pwm_in_i in clk cycles,
// publishes them once per PWM period, and raises stuck flags when rising edges stop.
module dpwm_duty_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             pwm_in_i,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [CNT_W-1:0] period_cnt_o,
  output logic             valid_o,
  output logic             stuck_high_o,
  output logic             stuck_low_o
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_LOW  = 3'd1;
  localparam logic [2:0] WAIT_RISE = 3'd2;
  localparam logic [2:0] MEAS      = 3'd3;
  localparam logic [2:0] STUCK     = 3'd4;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT);

  logic             s1_q, s2_q, s3_q;
  logic [1:0]       fill_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic             valid_q, valid_d;
  logic             rise;
  logic [CNT_W-1:0] tmo_inc;
  logic             tmo_hit;

  // Stage 0: synchronizer and history flop. fill_q marks when s2 holds a genuine
  // sample after reset, so a pwm_in_i that is high at reset release is not read as low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      fill_q <= 2'b00;
    end else begin
      s1_q   <= pwm_in_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      fill_q <= {fill_q[0], 1'b1};
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign tmo_inc = tmo_q + ONE;
  assign tmo_hit = (tmo_inc == TMO_LIM);

  always_comb begin
    state_d      = state_q;
    per_d        = per_q;
    hi_d         = hi_q;
    tmo_d        = tmo_q;
    high_cnt_d   = high_cnt_q;
    period_cnt_d = period_cnt_q;
    valid_d      = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      per_d   = '0;
      hi_d    = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_LOW;
          per_d   = '0;
          hi_d    = '0;
          tmo_d   = '0;
        end
        WAIT_LOW: begin
          tmo_d = tmo_inc;
          if (tmo_hit)                  state_d = STUCK;
          else if (!s2_q && fill_q[1])  state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            state_d = MEAS;
            per_d   = ONE;
            hi_d    = ONE;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_inc;
            if (tmo_hit) state_d = STUCK;
          end
        end
        MEAS: begin
          // A rise coinciding with the timeout is a period of exactly TIMEOUT: publish it.
          if (rise) begin
            high_cnt_d   = hi_q;
            period_cnt_d = per_q;
            valid_d      = 1'b1;
            per_d        = ONE;
            hi_d         = ONE;
            tmo_d        = '0;
          end else begin
            per_d = per_q + ONE;
            hi_d  = hi_q + CNT_W'(s2_q);
            tmo_d = tmo_inc;
            if (tmo_hit) state_d = STUCK;
          end
        end
        STUCK: begin
          if (rise) begin
            state_d = MEAS;
            per_d   = ONE;
            hi_d    = ONE;
            tmo_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Stage 1: measurement state and published outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      per_q        <= '0;
      hi_q         <= '0;
      tmo_q        <= '0;
      high_cnt_q   <= '0;
      period_cnt_q <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      per_q        <= per_d;
      hi_q         <= hi_d;
      tmo_q        <= tmo_d;
      high_cnt_q   <= high_cnt_d;
      period_cnt_q <= period_cnt_d;
      valid_q      <= valid_d;
    end
  end

  assign high_cnt_o   = high_cnt_q;
  assign period_cnt_o = period_cnt_q;
  assign valid_o      = valid_q;
  // Flags follow the synchronized level directly while stuck, and drop as soon as STUCK is left.
  assign stuck_high_o = (state_q == STUCK) &  s2_q;
  assign stuck_low_o  = (state_q == STUCK) & ~s2_q;

endmodule

// File: doc/dpwm_duty_capture.md
# dpwm_duty_capture

Measures the high time and period of a PWM waveform in `clk` cycles and publishes them once per PWM period with a one-cycle valid strobe. It is the receive end of the DPWM path: it recovers the duty command that a counter-based DPWM produced. It is used for closed-loop self-check of the DPWM/dither chain and for bench observation of gate-drive timing. It also flags stuck-high (100 %) and stuck-low (0 %) outputs via a no-edge timeout.

## Interface
- `CNT_W`, default 8: width of the high-time and period counters and outputs.
- `TIMEOUT`, default 200: cycles without an accepted rising edge before a stuck flag is raised. Legal range 2 .. 2^CNT_W−1, so the counters never wrap.
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `en`  in  1: capture enable. Low forces IDLE.
- `pwm_in`  in  1: PWM waveform. May be asynchronous to `clk`.
- `high_cnt`  out  CNT_W: synchronized-high samples in the last complete period.
- `period_cnt`  out  CNT_W: cycles from one accepted rising edge to the next.
- `valid`  out  1: one-cycle strobe when `high_cnt`/`period_cnt` update.
- `stuck_high`  out  1: no rising edge for TIMEOUT cycles, input high.
- `stuck_low`  out  1: no rising edge for TIMEOUT cycles, input low.

## Operation
- **Input path:** 2-flop synchronizer s1→s2, plus history flop s3. All three reset to 0. `rise` = s2 & ~s3. All measurement uses s2 only.
- **States:** IDLE, WAIT_LOW, WAIT_RISE, MEAS, STUCK.
- **IDLE:**
  - Counters cleared, flags 0.
  - en=1 → WAIT_LOW.
- **WAIT_LOW:**
  - s2=0 → WAIT_RISE.
  - This state rejects the false rise caused by pwm_in being high at reset release.
- **WAIT_RISE:**
  - `rise` → MEAS, with per=1 and hi=1.
  - No publish on this first edge.
- **MEAS:**
  - Each cycle: per+=1, and hi+=1 when s2=1.
  - On `rise`: publish high_cnt←hi, period_cnt←per, valid=1, then reload per=1, hi=1.
- **Timeout counter `tmo`:**
  - Cleared on entry to WAIT_LOW and on every accepted `rise`.
  - Increments in WAIT_LOW, WAIT_RISE and MEAS.
  - When tmo reaches TIMEOUT → STUCK, with stuck_high=s2 and stuck_low=~s2.
- **STUCK:**
  - Flags track s2 while in this state.
  - `rise` → MEAS, flags cleared, per=1, hi=1, no publish.
- **Output hold:** high_cnt and period_cnt hold their last published values in every state, including STUCK and IDLE. Only reset clears them.
- **en deasserted (any state):** → IDLE next cycle, flags cleared, no valid. If en falls in the same cycle as `rise`, en wins and there is no publish.
- **Simultaneous rise and timeout in MEAS:** rise wins; publish and stay in MEAS.
- **Reset mid-period:** all state is discarded and no partial measurement is published.
- **Width rule:** per ≤ TIMEOUT ≤ 2^CNT_W−1, so no saturation logic is needed. A period longer than TIMEOUT is reported as stuck, never measured.

## Timing
- **Reset values:** high_cnt=0, period_cnt=0, valid=0, stuck_high=0, stuck_low=0, state IDLE, s1=s2=s3=0.
- **Publish latency:** valid is high in the cycle after the 3rd rising clk edge at which pwm_in is sampled high (2 synchronizer edges + 1 output-register edge).
- **Measurement skew:** synchronizer delay is identical for both edges, so the measurement has no systematic offset. Asynchronous input gives ±1 cycle per edge.
- **Output timing:** valid is high for exactly one cycle, and high_cnt/period_cnt change only on the same edge that raises valid.
- **Minimum measurable pulses:** 1-cycle high or low pulses are counted. The minimum period is 2 cycles.
- **Stuck-flag timing:** stuck flags rise TIMEOUT cycles after the last accepted rise, or after entry to WAIT_LOW. In STUCK they follow s2 with 0 extra latency, and they clear on the cycle after the rise that exits STUCK.

## Test plan
- **Steady PWM:** synchronous PWM, period 64, high 20, en=1 from reset.
  - No valid on the 1st edge.
  - Every later period: valid one cycle, high_cnt=20, period_cnt=64.
  - Check 3-edge latency from pwm_in rise.
- **Duty sweep:** high ∈ {1, 32, 63} at period 64 → high_cnt equals the high time exactly, period_cnt=64. Each step change shows at most one intermediate mixed period.
- **Stuck high:** pwm_in held high at and after reset, TIMEOUT=200.
  - No valid.
  - stuck_high=1 at tmo=200.
  - Then period 64, high 10 → flags clear; first publish at the 2nd subsequent rise: 10/64.
- **Stuck low:** pwm_in low for 250 cycles after lock → stuck_low=1, stuck_high=0, outputs hold the prior values.
- **en/rise collision:** en dropped in the same cycle as `rise` → no valid, IDLE, flags 0.
  - en re-raised → first publish only after WAIT_LOW, WAIT_RISE and one full period.
- **Reset mid-period:** rst pulsed mid-high → all outputs 0 asynchronously, no spurious valid, normal capture resumes.
